uart_tx_fifo: RTL and testbench

Byte buffer sitting directly upstream of the UART transmitter. Accepts bytes from a producer at full clock rate, stores up to DEPTH of them, and drains them one at a time into the transmitter over its `tx_req`/`tx_data`/`tx_ack` handshake. Producers can burst a message without waiting on the serial bit rate.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_fifo_mem.sv | 35 +++
 rtl/uart_tx_fifo.sv | 155 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART datapath stages.
//   tx_state_t          : handshake FSM states for the TX byte buffer
//   UART_TX_FIFO_DEPTH  : default number of buffered bytes
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } tx_state_t;

    localparam int UART_TX_FIFO_DEPTH = 16;

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem
// DEPTH x 8 storage array for the TX byte buffer.
//   clk   in  : system clock
//   we    in  : write enable, writes wdata at waddr on the rising edge
//   waddr in  : write address
//   wdata in  : byte to store
//   raddr in  : read address
//   rdata out : byte at raddr, combinational read
module sync_fifo_mem
    import uart_pkg::*;
#(
    parameter int  DEPTH = UART_TX_FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Storage is deliberately not reset: the pointers alone decide
    // which entries are meaningful.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Byte buffer in front of the UART transmitter. Bytes are pushed at full
// clock rate and drained one at a time over a req/ack handshake.
//   clk      in  : system clock
//   rst      in  : synchronous active-high reset
//   wr_en    in  : push wr_data this cycle
//   wr_data  in  : byte to queue
//   full     out : stored level equals DEPTH
//   empty    out : stored level is zero
//   level    out : bytes stored, not counting the byte in the output register
//   tx_req   out : tx_data is valid for the transmitter
//   tx_data  out : byte presented to the transmitter
//   tx_ack   in  : transmitter accepted the byte (pulse or level)
//   ovf      out : sticky overflow flag
//   ovf_clr  in  : clears ovf (and ovf_cnt)
//   ovf_cnt  out : saturating dropped-byte count, only when the macro
//                  UART_TX_FIFO_OVF_CNT_EN is defined
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int  DEPTH = UART_TX_FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level,
    output logic        tx_req,
    output logic [7:0]  tx_data,
    input  logic        tx_ack,
    output logic        ovf,
    input  logic        ovf_clr
`ifdef UART_TX_FIFO_OVF_CNT_EN
    ,
    output logic [7:0]  ovf_cnt
`endif
);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   level_q;
    logic [7:0]    rd_data;
    tx_state_t     state;
    logic          push;
    logic          pop;
    logic          drop;

    sync_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wptr),
        .wdata (wr_data),
        .raddr (rptr),
        .rdata (rd_data)
    );

    // Flags are decoded from the registered level, so a push arriving in
    // the same cycle as a pop from a full buffer is still dropped.
    assign level = level_q;
    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);
    assign push  = wr_en && !full;
    assign drop  = wr_en && full;
    assign pop   = (state == IDLE) && !empty;

    // Pointer and level bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Handshake FSM. RELEASE waits for ack to fall so a level-style ack
    // cannot accept two bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx_req  <= 1'b0;
            tx_data <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        tx_data <= rd_data;
                        tx_req  <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (tx_ack) begin
                        tx_req <= 1'b0;
                        state  <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!tx_ack) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    tx_req <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Sticky overflow flag; a new drop wins over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

`ifdef UART_TX_FIFO_OVF_CNT_EN
    // Dropped-byte counter saturating at 8'hFF; clear plus drop gives 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt <= 8'h00;
        end else if (drop) begin
            if (ovf_clr) begin
                ovf_cnt <= 8'h01;
            end else if (ovf_cnt != 8'hFF) begin
                ovf_cnt <= ovf_cnt + 8'h01;
            end
        end else if (ovf_clr) begin
            ovf_cnt <= 8'h00;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
// Self-checking bench for uart_tx_fifo. A queue-based model predicts the
// outputs every cycle; directed tests add hand-computed expectations.
// Honours UART_TX_FIFO_OVF_CNT_EN for the ovf_cnt port.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        full;
    logic        empty;
    logic [AW:0] level;
    logic        tx_req;
    logic [7:0]  tx_data;
    logic        tx_ack;
    logic        ovf;
    logic        ovf_clr;
`ifdef UART_TX_FIFO_OVF_CNT_EN
    logic [7:0]  ovf_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    uart_tx_fifo #(
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .tx_req  (tx_req),
        .tx_data (tx_data),
        .tx_ack  (tx_ack),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
`ifdef UART_TX_FIFO_OVF_CNT_EN
        ,
        .ovf_cnt (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model: stored bytes as a queue plus the byte handed to
    // the transmitter and whether we are still waiting for ack to fall.
    logic [7:0] q [$];
    logic       out_busy  = 1'b0;
    logic       wait_low  = 1'b0;
    logic [7:0] tx_data_m = 8'h00;
    logic       ovf_m     = 1'b0;
    int         cnt_m     = 0;
    logic       model_on  = 1'b0;

    logic [7:0] sent [$];
    int         max_level = 0;

    // 0: ack low, 1: pulse 3 cycles after req, 2: hold 5 cycles, 3: immediate pulse
    int ack_mode = 0;

    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic w, input logic [7:0] d, input logic clr);
        wr_en   = w;
        wr_data = d;
        ovf_clr = clr;
        step();
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while ((q.size() != 0 || out_busy || wait_low) && n < budget) begin
            step();
            n++;
        end
        checkOutput("drain_within_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic checkSent(input string name, input int base, input int count);
        checkOutput({name, "_count"}, sent.size(), count);
        for (int i = 0; i < count && i < sent.size(); i++) begin
            checkOutput(name, sent[i], 32'((base + i) & 8'hFF));
        end
    endtask

    // Model update from the inputs the DUT samples at this edge.
    always @(posedge clk) begin
        logic can_pop;
        logic drop_m;
        if (rst) begin
            q.delete();
            out_busy  = 1'b0;
            wait_low  = 1'b0;
            tx_data_m = 8'h00;
            ovf_m     = 1'b0;
            cnt_m     = 0;
        end else begin
            drop_m  = wr_en && (q.size() == DEPTH);
            can_pop = !out_busy && !wait_low && (q.size() > 0);
            if (out_busy && tx_ack) begin
                out_busy = 1'b0;
                wait_low = 1'b1;
            end else if (wait_low && !tx_ack) begin
                wait_low = 1'b0;
            end
            if (can_pop) begin
                tx_data_m = q.pop_front();
                out_busy  = 1'b1;
            end
            if (wr_en && !drop_m) begin
                q.push_back(wr_data);
            end
            if (drop_m) begin
                ovf_m = 1'b1;
                cnt_m = ovf_clr ? 1 : (cnt_m == 255 ? 255 : cnt_m + 1);
            end else if (ovf_clr) begin
                ovf_m = 1'b0;
                cnt_m = 0;
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (model_on) begin
            checkOutput("tx_req", tx_req, out_busy);
            checkOutput("tx_data", tx_data, tx_data_m);
            checkOutput("level", level, q.size());
            checkOutput("empty", empty, 32'(q.size() == 0));
            checkOutput("full", full, 32'(q.size() == DEPTH));
            checkOutput("ovf", ovf, ovf_m);
`ifdef UART_TX_FIFO_OVF_CNT_EN
            checkOutput("ovf_cnt", ovf_cnt, cnt_m);
`endif
            if (tx_req && tx_ack && !rst) begin
                sent.push_back(tx_data);
            end
            if (int'(level) > max_level) begin
                max_level = int'(level);
            end
        end
    end

    // Transmitter-side ack behaviour.
    initial begin
        int acnt = 0;
        int hold = 0;
        tx_ack = 1'b0;
        forever begin
            step();
            case (ack_mode)
                1: begin
                    if (tx_req && !tx_ack) begin
                        acnt++;
                        if (acnt == 3) begin
                            tx_ack = 1'b1;
                            acnt   = 0;
                        end
                    end else begin
                        tx_ack = 1'b0;
                    end
                end
                2: begin
                    if (hold > 0) begin
                        hold--;
                        tx_ack = (hold > 0);
                    end else if (tx_req) begin
                        tx_ack = 1'b1;
                        hold   = 5;
                    end else begin
                        tx_ack = 1'b0;
                    end
                end
                3: tx_ack = tx_req && !tx_ack;
                default: begin
                    tx_ack = 1'b0;
                    acnt   = 0;
                    hold   = 0;
                end
            endcase
        end
    end

    initial begin
        int pushed;
        int n;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        ovf_clr = 1'b0;
        step();
        step();
        rst      = 1'b0;
        model_on = 1'b1;

        // Reset values
        checkOutput("rst_tx_req", tx_req, 0);
        checkOutput("rst_tx_data", tx_data, 8'h00);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_level", level, 0);
        checkOutput("rst_ovf", ovf, 0);

        // Single byte with a delayed 1-cycle ack pulse
        $display("[TB] single byte");
        ack_mode = 1;
        sent.delete();
        applyStimulus(1'b1, 8'hA5, 1'b0);
        checkOutput("t1_level_after_push", level, 1);
        checkOutput("t1_req_not_yet", tx_req, 0);
        step();
        checkOutput("t1_req_up", tx_req, 1);
        checkOutput("t1_data", tx_data, 8'hA5);
        checkOutput("t1_level_after_pop", level, 0);
        waitIdle(50);
        checkSent("t1_sent", 8'hA5, 1);
        checkOutput("t1_req_end", tx_req, 0);
        checkOutput("t1_empty_end", empty, 1);

        // Ordered drain of a 16-byte burst
        $display("[TB] ordered drain");
        ack_mode = 0;
        sent.delete();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b0);
        end
        checkOutput("t2_level15", level, 15);
        checkOutput("t2_req", tx_req, 1);
        checkOutput("t2_head", tx_data, 8'h00);
        ack_mode = 3;
        waitIdle(300);
        checkSent("t2_sent", 8'h00, 16);

        // Overflow with the ack stalled
        $display("[TB] overflow");
        ack_mode = 0;
        sent.delete();
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b1, 8'(8'h20 + i), 1'b0);
        end
        checkOutput("t3_level", level, 16);
        checkOutput("t3_full", full, 1);
        checkOutput("t3_ovf", ovf, 1);
`ifdef UART_TX_FIFO_OVF_CNT_EN
        checkOutput("t3_ovf_cnt", ovf_cnt, 1);
`endif
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t3_ovf_cleared", ovf, 0);
`ifdef UART_TX_FIFO_OVF_CNT_EN
        checkOutput("t3_cnt_cleared", ovf_cnt, 0);
`endif
        applyStimulus(1'b1, 8'h99, 1'b1);
        checkOutput("t3_set_wins", ovf, 1);
`ifdef UART_TX_FIFO_OVF_CNT_EN
        checkOutput("t3_cnt_clr_drop", ovf_cnt, 1);
`endif
        applyStimulus(1'b0, 8'h00, 1'b1);
        ack_mode = 3;
        waitIdle(300);
        checkSent("t3_sent", 8'h20, 17);

        // Level-type ack held for 5 cycles
        $display("[TB] level ack");
        ack_mode = 2;
        sent.delete();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'(8'h41 + i), 1'b0);
        end
        waitIdle(300);
        checkSent("t4_sent", 8'h41, 3);

        // Continuous push and drain across the pointer wrap
        $display("[TB] push and pop with wrap");
        ack_mode  = 3;
        sent.delete();
        max_level = 0;
        pushed    = 0;
        n         = 0;
        while (pushed < 40 && n < 2000) begin
            if (!full) begin
                applyStimulus(1'b1, 8'(8'h80 + pushed), 1'b0);
                pushed++;
            end else begin
                step();
            end
            n++;
        end
        checkOutput("t5_all_pushed", pushed, 40);
        waitIdle(500);
        checkSent("t5_sent", 8'h80, 40);
        checkOutput("t5_level_bound", 32'(max_level <= DEPTH), 1);

        // Reset in the middle of a transfer
        $display("[TB] reset mid-operation");
        ack_mode = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 8'(8'h61 + i), 1'b0);
        end
        checkOutput("t6_level5", level, 5);
        checkOutput("t6_req", tx_req, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("t6_req_dropped", tx_req, 0);
        checkOutput("t6_level0", level, 0);
        checkOutput("t6_empty", empty, 1);
        checkOutput("t6_ovf", ovf, 0);
        sent.delete();
        ack_mode = 3;
        applyStimulus(1'b1, 8'h5A, 1'b0);
        waitIdle(50);
        checkSent("t6_sent", 8'h5A, 1);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
